// File: rtl/disp_mem_arbiter.sv
// disp_mem_arbiter
//   Round-robin arbiter that shares the single framebuffer memory port
//   between N display requesters (sample plotter, grid/text renderer,
//   screen clear, LCD refresh reader). Only one memory transaction is in
//   flight at a time. The winner's addr/data/wr are captured and held on
//   the memory port until the memory accepts them. Completion (and read
//   data) is returned to the owning requester only.
//
// Ports
//   clkSYS      system clock, all logic on the rising edge
//   n_reset     synchronous active-low reset
//   req[N]      per-requester request, held until its own ack
//   wr[N]       per-requester direction, 1 = write, 0 = read
//   addr        packed requester addresses, slice i = [i*AN +: AN]
//   data        packed requester write data, slice i = [i*DN +: DN]
//   ack[N]      one-cycle completion pulse to the owner
//   rdata       read data, valid in the ack cycle of a read
//   grant       index of the current/last owner
//   busy        high whenever a transaction is being handled
//   mem_req     memory request, held until mem_ack
//   mem_wr      memory write enable
//   mem_addr    memory address
//   mem_data    memory write data
//   mem_ack     memory accepted the request (one-cycle pulse)
//   mem_rvalid  memory read data valid (one-cycle pulse)
//   mem_rdata   memory read data

module disp_mem_arbiter #(
   parameter int N  = 4,
   parameter int AN = 24,
   parameter int DN = 16
) (
   input  logic                 clkSYS,
   input  logic                 n_reset,
   input  logic [N-1:0]         req,
   input  logic [N-1:0]         wr,
   input  logic [N*AN-1:0]      addr,
   input  logic [N*DN-1:0]      data,
   output logic [N-1:0]         ack,
   output logic [DN-1:0]        rdata,
   output logic [$clog2(N)-1:0] grant,
   output logic                 busy,
   output logic                 mem_req,
   output logic                 mem_wr,
   output logic [AN-1:0]        mem_addr,
   output logic [DN-1:0]        mem_data,
   input  logic                 mem_ack,
   input  logic                 mem_rvalid,
   input  logic [DN-1:0]        mem_rdata
);

   localparam int GW = $clog2(N);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_RD = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t         state_r;
   state_t         state_s;
   logic [GW-1:0]  grant_r;
   logic [GW-1:0]  grant_s;
   logic [GW-1:0]  ptr_r;
   logic [GW-1:0]  ptr_s;
   logic [N-1:0]   ack_r;
   logic [N-1:0]   ack_s;
   logic [DN-1:0]  rdata_r;
   logic [DN-1:0]  rdata_s;
   logic           busy_r;
   logic           busy_s;
   logic           mem_req_r;
   logic           mem_req_s;
   logic           mem_wr_r;
   logic           mem_wr_s;
   logic [AN-1:0]  mem_addr_r;
   logic [AN-1:0]  mem_addr_s;
   logic [DN-1:0]  mem_data_r;
   logic [DN-1:0]  mem_data_s;

   logic [AN-1:0]  addr_a_s [N];
   logic [DN-1:0]  data_a_s [N];
   logic           any_req_s;
   logic [GW-1:0]  win_s;
   logic [N-1:0]   owner_onehot_s;

   // First set request bit searching upward from ptr+1, wrapping modulo N.
   // Returns ptr itself when nothing is set; callers gate on any request.
   function automatic logic [GW-1:0] rr_pick(input logic [N-1:0] r, input logic [GW-1:0] p);
      logic [GW-1:0] w;
      logic [GW-1:0] idx;
      logic          found;
      w     = p;
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
         idx = GW'((int'(p) + k) % N);
         if (!found && r[idx]) begin
            w     = idx;
            found = 1'b1;
         end
      end
      return w;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_unpack
         assign addr_a_s[gi] = addr[gi*AN +: AN];
         assign data_a_s[gi] = data[gi*DN +: DN];
      end
   endgenerate

   assign any_req_s      = |req;
   assign win_s          = rr_pick(req, ptr_r);
   assign owner_onehot_s = {{(N-1){1'b0}}, 1'b1} << grant_r;
   assign busy_s         = (state_s != IDLE);

   // Next-state and next-output decode for the single in-flight transaction
   always_comb begin
      state_s    = state_r;
      grant_s    = grant_r;
      ptr_s      = ptr_r;
      ack_s      = {N{1'b0}};
      rdata_s    = rdata_r;
      mem_req_s  = mem_req_r;
      mem_wr_s   = mem_wr_r;
      mem_addr_s = mem_addr_r;
      mem_data_s = mem_data_r;
      case (state_r)
         IDLE: begin
            if (any_req_s) begin
               state_s    = ISSUE;
               grant_s    = win_s;
               ptr_s      = win_s;
               mem_req_s  = 1'b1;
               mem_wr_s   = wr[win_s];
               mem_addr_s = addr_a_s[win_s];
               mem_data_s = data_a_s[win_s];
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            if (mem_ack) begin
               mem_req_s = 1'b0;
               if (mem_wr_r) begin
                  state_s = DONE;
                  ack_s   = owner_onehot_s;
               end else if (mem_rvalid) begin
                  // read data arriving together with the accept skips WAIT_RD
                  rdata_s = mem_rdata;
                  state_s = DONE;
                  ack_s   = owner_onehot_s;
               end else begin
                  state_s = WAIT_RD;
               end
            end else begin
               state_s = ISSUE;
            end
         end
         WAIT_RD: begin
            if (mem_rvalid) begin
               rdata_s = mem_rdata;
               state_s = DONE;
               ack_s   = owner_onehot_s;
            end else begin
               state_s = WAIT_RD;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and registered-output update; reset abandons any access in flight
   always_ff @(posedge clkSYS) begin
      if (!n_reset) begin
         state_r    <= IDLE;
         grant_r    <= {GW{1'b0}};
         ptr_r      <= GW'(N - 1);
         ack_r      <= {N{1'b0}};
         rdata_r    <= {DN{1'b0}};
         busy_r     <= 1'b0;
         mem_req_r  <= 1'b0;
         mem_wr_r   <= 1'b0;
         mem_addr_r <= {AN{1'b0}};
         mem_data_r <= {DN{1'b0}};
      end else begin
         state_r    <= state_s;
         grant_r    <= grant_s;
         ptr_r      <= ptr_s;
         ack_r      <= ack_s;
         rdata_r    <= rdata_s;
         busy_r     <= busy_s;
         mem_req_r  <= mem_req_s;
         mem_wr_r   <= mem_wr_s;
         mem_addr_r <= mem_addr_s;
         mem_data_r <= mem_data_s;
      end
   end

   assign ack      = ack_r;
   assign rdata    = rdata_r;
   assign grant    = grant_r;
   assign busy     = busy_r;
   assign mem_req  = mem_req_r;
   assign mem_wr   = mem_wr_r;
   assign mem_addr = mem_addr_r;
   assign mem_data = mem_data_r;

endmodule
